slave_port: RTL and testbench
=============================

# slave_port

Slave-side bit-serial bus port, sitting directly upstream of each memory slave. It deserializes request frames from the bit-serial bus into a single-cycle parallel request (valid/addr/wdata/we), waits for the slave's ready, error or split response, and serializes the response frame back onto the bus. On split-capable slaves it forwards split requests and holds the bus in split state until the slave returns data. A no-response timeout guards against a hung slave.

## Interface
- `SPLIT_CAPABLE`, default 0: enables `split_start_o` generation and the SPLIT state.
- `TIMEOUT_CYCLES`, default 15: WAIT cycles without a slave response before an error response is sent; legal range 1..255.
- `clk_i` in 1: system clock, posedge.
- `rst_i` in 1: one clock; reset is asynchronous and active-high.
- `bus_rx_valid_i` in 1: request bit strobe.
- `bus_rx_bit_i` in 1: request bit, sampled only when the strobe is high.
- `bus_tx_valid_o` out 1: response bit strobe.
- `bus_tx_bit_o` out 1: response bit.
- `bus_busy_o` out 1: port is not IDLE.
- `bus_split_o` out 1: split transaction pending.
- `split_req_i` in 1: master requests split handling for the current read.
- `valid_o` out 1: request pulse to the slave.
- `addr_o` out ADDR_WIDTH: local address.
- `wdata_o` out DATA_WIDTH: write data.
- `we_o` out 1: write enable.
- `split_start_o` out 1: split request, qualified by `valid_o`.
- `ready_i` in 1: slave response.
- `rdata_i` in DATA_WIDTH: slave read data.
- `err_i` in 1: slave address error.
- `split_busy_i` in 1: slave split busy.
- `split_ready_i` in 1: slave split data ready.

## Operation
- Request frame, all fields LSB first:
  - bit 0: `we`.
  - next ADDR_WIDTH (14) bits: addr.
  - if `we`: DATA_WIDTH (8) bits of wdata.
  - Read frame = 15 bits; write frame = 23 bits.
  - Gaps are allowed: bits advance only on `bus_rx_valid_i`.
- States: IDLE, RX, REQ, WAIT, SPLIT, TX.
- IDLE → RX on the first strobe; that bit is `we`.
- RX → REQ when the bit counter reaches 15 (read) or 23 (write).
- REQ (one cycle):
  - `valid_o`=1 with `addr_o`/`wdata_o`/`we_o` from the shift register.
  - `split_start_o` = SPLIT_CAPABLE & `split_req_i` & !`we`.
  - Next state: WAIT.
- WAIT, in priority order:
  - `ready_i`: capture `err_i` and `rdata_i`, go to TX.
  - SPLIT_CAPABLE & `split_busy_i`: go to SPLIT.
  - Timeout counter reaches TIMEOUT_CYCLES: go to TX with err=1 and rdata=0.
  - Otherwise: increment the timeout counter.
- SPLIT:
  - `bus_split_o`=1; no timeout.
  - On `ready_i` or `split_ready_i`: capture `rdata_i`, set err=0, go to TX.
- TX:
  - Bit 0 = err.
  - Reads without error: then 8 rdata bits, LSB first.
  - `bus_tx_valid_o` is high on every TX cycle with no gaps.
  - Write response = 1 bit. Read response = 1 bit (err) or 9 bits (ok).
  - Next state after the last bit: IDLE.
- `bus_rx_valid_i` outside IDLE/RX is ignored; the master must observe `bus_busy_o`.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame or mid-wait aborts the transaction with no response bits.
- A slave response arriving after reset deasserts is ignored in IDLE.
- `valid_o` asserts on the cycle after the last request bit is sampled.
- Against a single-cycle slave, `ready_i` arrives one cycle after `valid_o`.
- First response bit appears the cycle after `ready_i`.
- Read latency, last rx bit to first tx bit: 3 cycles. WAIT lasts 1 cycle for a single-cycle slave.
- Timeout: TX is entered after TIMEOUT_CYCLES+1 WAIT cycles.
- `bus_busy_o` is high from the cycle after the first strobe through the last TX bit.
- Simultaneous `ready_i` and `split_busy_i` in WAIT: `ready_i` wins.
- `split_busy_i` with SPLIT_CAPABLE=0: ignored.
- Counter widths:
  - Bit counter: 5 bits.
  - Timeout counter: 8 bits, saturating.

## Structure
- `bus_pkg` gets:
  - `slv_port_state_e` (6 states).
  - `RX_READ_BITS`=15, `RX_WRITE_BITS`=23.
  - `RSP_READ_BITS`=9.
- `slave_port` reuses the existing `ADDR_WIDTH`/`DATA_WIDTH` from `bus_pkg`.
- One sub-module, `serial_shift_rx`: strobe-qualified LSB-first shift register plus bit counter, reporting the frame-complete count. It is reused by the master-side response deserializer.

## Test plan
- Write frame `we`=1, addr 0x005, data 0xA5, with one idle gap mid-frame → single `valid_o` pulse with addr 0x005, wdata 0xA5, `we`=1; response is a single bit 0.
- Read frame for addr 0x005, slave returns 0xA5 → response bits 0,1,0,1,0,0,1,0,1; first tx bit 3 cycles after the last rx bit.
- Read of addr 0x1FFF with slave `err_i`=1 → response is a single bit 1; `bus_busy_o` drops the next cycle.
- SPLIT_CAPABLE=1, `split_req_i`=1, slave busy for 4 cycles and then returns 0x3C → `split_start_o` pulses with `valid_o`; `bus_split_o` high throughout; response 0 followed by 0x3C LSB first.
- Slave never responds, TIMEOUT_CYCLES=15 → error bit 1 after 16 WAIT cycles.
- Reset asserted during RX bit 10 → all outputs 0 and state IDLE; a new full frame after reset is processed normally.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bit-serial bus: local address/data widths,
// request/response frame lengths and the slave-port state encoding.
// ---------------------------------------------------------------------------
package bus_pkg;

   localparam int ADDR_WIDTH    = 14;
   localparam int DATA_WIDTH    = 8;

   // Request frame lengths: we bit + addr (+ wdata for writes)
   localparam int RX_READ_BITS  = 1 + ADDR_WIDTH;
   localparam int RX_WRITE_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;

   // Successful read response: err bit + rdata
   localparam int RSP_READ_BITS = 1 + DATA_WIDTH;

   typedef enum logic [2:0] {
      SP_IDLE,
      SP_RX,
      SP_REQ,
      SP_WAIT,
      SP_SPLIT,
      SP_TX
   } slv_port_state_e;

endpackage

// File: rtl/serial_shift_rx.sv
// ---------------------------------------------------------------------------
// serial_shift_rx
// Strobe-qualified LSB-first deserializer with a bit counter. Each strobed
// bit lands at the position given by the current count, so the first bit of
// a frame ends up in o_data[0]. o_done flags the strobe that completes a
// frame of i_len bits, letting the owner change state on the same edge the
// last bit is captured.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_clr         synchronous clear of data and count (wins over i_valid)
//   i_valid       bit strobe
//   i_bit         serial bit, sampled only with i_valid
//   i_len         expected frame length in bits
//   o_data        assembled frame
//   o_done        current strobe carries the final bit of the frame
// ---------------------------------------------------------------------------
module serial_shift_rx #(
   parameter int WIDTH = 23,
   parameter int CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_valid,
   input  logic             i_bit,
   input  logic [CNT_W-1:0] i_len,
   output logic [WIDTH-1:0] o_data,
   output logic             o_done
);

   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_data  <= '0;
         r_count <= '0;
      end else if (i_valid) begin
         // Data is cleared between frames, so OR-ing in the new bit is enough
         r_data <= r_data | (WIDTH'(i_bit) << r_count);
         if (r_count != '1) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign o_data = r_data;
   assign o_done = i_valid && ((r_count + CNT_W'(1)) == i_len);

endmodule

// File: rtl/slave_port.sv
// ---------------------------------------------------------------------------
// slave_port
// Slave-side bit-serial bus port. Deserializes a request frame
// (we, addr, [wdata], LSB first), issues a one-cycle parallel request to the
// slave, waits for ready/error/split, and serializes the response frame
// (err, [rdata]) back onto the bus. A saturating no-response timer turns a
// hung slave into an error response.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   bus_rx_valid_i/bus_rx_bit_i   request bit strobe / bit
//   bus_tx_valid_o/bus_tx_bit_o   response bit strobe / bit
//   bus_busy_o                    port not IDLE
//   bus_split_o                   split transaction pending
//   split_req_i                   master asks for split handling of a read
//   valid_o/addr_o/wdata_o/we_o   request to the slave
//   split_start_o                 split request, qualified by valid_o
//   ready_i/rdata_i/err_i         slave response
//   split_busy_i/split_ready_i    slave split status
// ---------------------------------------------------------------------------
module slave_port
   import bus_pkg::*;
#(
   parameter bit          SPLIT_CAPABLE  = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  bus_rx_valid_i,
   input  logic                  bus_rx_bit_i,
   output logic                  bus_tx_valid_o,
   output logic                  bus_tx_bit_o,
   output logic                  bus_busy_o,
   output logic                  bus_split_o,
   input  logic                  split_req_i,
   output logic                  valid_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  we_o,
   output logic                  split_start_o,
   input  logic                  ready_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic                  err_i,
   input  logic                  split_busy_i,
   input  logic                  split_ready_i
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   slv_port_state_e           r_state;
   logic                      r_valid;
   logic [7:0]                r_tmo;
   logic [DATA_WIDTH-1:0]     r_tx_sr;
   logic [3:0]                r_tx_cnt;
   logic                      r_tx_valid;
   logic                      r_tx_bit;

   logic [RX_WRITE_BITS-1:0]  w_rx_data;
   logic                      w_rx_take;
   logic                      w_rx_clr;
   logic                      w_rx_done;
   logic [4:0]                w_frame_len;
   logic                      w_req_we;
   logic                      w_tx_last;
   logic                      w_load;
   logic                      w_load_err;
   logic [DATA_WIDTH-1:0]     w_load_rdata;

   // Strobes outside IDLE/RX are ignored; the master must honour bus_busy_o
   assign w_rx_take   = bus_rx_valid_i && ((r_state == SP_IDLE) || (r_state == SP_RX));
   assign w_tx_last   = (r_state == SP_TX) && (r_tx_cnt == 4'd0);
   assign w_rx_clr    = w_tx_last;
   assign w_req_we    = w_rx_data[0];
   // Register is cleared in IDLE, so bit 0 only reads as 1 once a write's we bit is in
   assign w_frame_len = w_req_we ? 5'(RX_WRITE_BITS) : 5'(RX_READ_BITS);

   serial_shift_rx #(
      .WIDTH (RX_WRITE_BITS),
      .CNT_W (5)
   ) u_rx (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_clr   (w_rx_clr),
      .i_valid (w_rx_take),
      .i_bit   (bus_rx_bit_i),
      .i_len   (w_frame_len),
      .o_data  (w_rx_data),
      .o_done  (w_rx_done)
   );

   // Response capture: ready beats split_busy beats timeout
   always_comb begin
      w_load       = 1'b0;
      w_load_err   = 1'b0;
      w_load_rdata = '0;
      if (r_state == SP_WAIT) begin
         if (ready_i) begin
            w_load       = 1'b1;
            w_load_err   = err_i;
            w_load_rdata = rdata_i;
         end else if (!(SPLIT_CAPABLE && split_busy_i) && (r_tmo == TMO_LIMIT)) begin
            w_load     = 1'b1;
            w_load_err = 1'b1;
         end
      end else if (r_state == SP_SPLIT) begin
         if (ready_i || split_ready_i) begin
            w_load       = 1'b1;
            w_load_rdata = rdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= SP_IDLE;
         r_valid    <= 1'b0;
         r_tmo      <= '0;
         r_tx_sr    <= '0;
         r_tx_cnt   <= '0;
         r_tx_valid <= 1'b0;
         r_tx_bit   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_load) begin
            // First response bit (err) goes out the cycle after the response
            r_state    <= SP_TX;
            r_tx_valid <= 1'b1;
            r_tx_bit   <= w_load_err;
            r_tx_sr    <= w_load_rdata;
            r_tx_cnt   <= (w_req_we || w_load_err) ? 4'd0 : 4'(RSP_READ_BITS - 1);
         end else begin
            case (r_state)
               SP_IDLE: begin
                  if (bus_rx_valid_i) r_state <= SP_RX;
               end
               SP_RX: begin
                  if (w_rx_done) begin
                     r_state <= SP_REQ;
                     r_valid <= 1'b1;
                  end
               end
               SP_REQ: begin
                  r_state <= SP_WAIT;
                  r_tmo   <= '0;
               end
               SP_WAIT: begin
                  if (SPLIT_CAPABLE && split_busy_i) begin
                     r_state <= SP_SPLIT;
                  end else if (r_tmo != 8'hFF) begin
                     r_tmo <= r_tmo + 8'd1;
                  end
               end
               SP_SPLIT: begin
                  r_state <= SP_SPLIT;
               end
               SP_TX: begin
                  if (r_tx_cnt == 4'd0) begin
                     r_state    <= SP_IDLE;
                     r_tx_valid <= 1'b0;
                     r_tx_bit   <= 1'b0;
                  end else begin
                     r_tx_bit <= r_tx_sr[0];
                     r_tx_sr  <= r_tx_sr >> 1;
                     r_tx_cnt <= r_tx_cnt - 4'd1;
                  end
               end
               default: r_state <= SP_IDLE;
            endcase
         end
      end
   end

   assign bus_tx_valid_o = r_tx_valid;
   assign bus_tx_bit_o   = r_tx_bit;
   assign bus_busy_o     = (r_state != SP_IDLE);
   assign bus_split_o    = (r_state == SP_SPLIT);
   assign valid_o        = r_valid;
   assign we_o           = w_req_we;
   assign addr_o         = w_rx_data[ADDR_WIDTH:1];
   assign wdata_o        = w_rx_data[ADDR_WIDTH+1 +: DATA_WIDTH];
   assign split_start_o  = r_valid && SPLIT_CAPABLE && split_req_i && !w_req_we;

endmodule

// File: tb/tb_slave_port.sv
// ---------------------------------------------------------------------------
// tb_slave_port
// Two ports share the bus and slave stimulus: u_dut0 without split support,
// u_dut1 with split support. Directed vectors from a table plus hand-written
// sequences for split, timeout and reset-abort behaviour.
// ---------------------------------------------------------------------------
module tb_slave_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic        rx_bit = 1'b0;
   logic        split_req = 1'b0;
   logic        ready = 1'b0;
   logic [7:0]  rdata = 8'h00;
   logic        err = 1'b0;
   logic        split_busy = 1'b0;
   logic        split_ready = 1'b0;

   logic        tx_valid0, tx_bit0, busy0, bsplit0, valid0, we0, sstart0;
   logic [13:0] addr0;
   logic [7:0]  wdata0;
   logic        tx_valid1, tx_bit1, busy1, bsplit1, valid1, we1, sstart1;
   logic [13:0] addr1;
   logic [7:0]  wdata1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t_last = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   slave_port u_dut0 (
      .clk_i(clk), .rst_i(rst), .bus_rx_valid_i(rx_valid), .bus_rx_bit_i(rx_bit),
      .bus_tx_valid_o(tx_valid0), .bus_tx_bit_o(tx_bit0), .bus_busy_o(busy0),
      .bus_split_o(bsplit0), .split_req_i(split_req), .valid_o(valid0),
      .addr_o(addr0), .wdata_o(wdata0), .we_o(we0), .split_start_o(sstart0),
      .ready_i(ready), .rdata_i(rdata), .err_i(err), .split_busy_i(split_busy),
      .split_ready_i(split_ready)
   );

   slave_port #(.SPLIT_CAPABLE(1'b1), .TIMEOUT_CYCLES(15)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .bus_rx_valid_i(rx_valid), .bus_rx_bit_i(rx_bit),
      .bus_tx_valid_o(tx_valid1), .bus_tx_bit_o(tx_bit1), .bus_busy_o(busy1),
      .bus_split_o(bsplit1), .split_req_i(split_req), .valid_o(valid1),
      .addr_o(addr1), .wdata_o(wdata1), .we_o(we1), .split_start_o(sstart1),
      .ready_i(ready), .rdata_i(rdata), .err_i(err), .split_busy_i(split_busy),
      .split_ready_i(split_ready)
   );

   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      logic        err;
      int          dly;
      bit          gap;
      logic [8:0]  exp_rsp;   // bit k = k-th response bit
      int          exp_len;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic we, input logic [13:0] addr,
                             input logic [7:0] wdata, input bit gap);
      logic [22:0] f;
      int n;
      f = {wdata, addr, we};
      n = we ? 23 : 15;
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_bit   = f[i];
         t_last   = cyc;
         tick();
         if (i == 0) chk("busy_after_first_strobe", busy0, 1);
         if (gap && i == 7) begin
            rx_valid = 1'b0;
            rx_bit   = 1'b0;
            tick();
         end
      end
      rx_valid = 1'b0;
      rx_bit   = 1'b0;
   endtask

   task automatic collect(output logic [8:0] r0, output int n0,
                          output logic [8:0] r1, output int n1);
      r0 = '0; r1 = '0; n0 = 0; n1 = 0;
      for (int k = 0; k < 20; k++) begin
         if (!tx_valid0 && !tx_valid1) break;
         if (tx_valid0) begin
            if (n0 < 9) r0[n0] = tx_bit0;
            n0++;
         end
         if (tx_valid1) begin
            if (n1 < 9) r1[n1] = tx_bit1;
            n1++;
         end
         tick();
      end
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      logic [8:0] r0, r1;
      int n0, n1, lat;
      split_req = 1'b0;
      rdata = v.rdata;
      err   = v.err;
      send_frame(v.we, v.addr, v.wdata, v.gap);
      chk({tag, "_valid"}, valid0, 1);
      chk({tag, "_addr"}, addr0, v.addr);
      chk({tag, "_wdata"}, wdata0, v.we ? v.wdata : 8'h00);
      chk({tag, "_we"}, we0, v.we);
      chk({tag, "_split_start"}, sstart1, 0);
      tick();
      chk({tag, "_valid_single"}, valid0, 0);
      repeat (v.dly) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      lat = cyc - t_last;
      collect(r0, n0, r1, n1);
      if (!v.we && !v.err && v.dly == 0) chk({tag, "_read_latency"}, lat, 3);
      chk({tag, "_rsp0"}, r0, v.exp_rsp);
      chk({tag, "_len0"}, n0, v.exp_len);
      chk({tag, "_rsp1"}, r1, v.exp_rsp);
      chk({tag, "_len1"}, n1, v.exp_len);
      chk({tag, "_busy_drop"}, busy0, 0);
      err = 1'b0;
      rdata = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [8:0] r0, r1;
      int n0, n1, waits;
      logic [22:0] f;

      //           we    addr      wdata  rdata  err  dly gap  rsp      len
      vecs[0] = '{1'b1, 14'h0005, 8'hA5, 8'h00, 1'b0, 0, 1, 9'h000,  1};
      vecs[1] = '{1'b0, 14'h0005, 8'h00, 8'hA5, 1'b0, 0, 0, 9'h14A,  9};
      vecs[2] = '{1'b0, 14'h1FFF, 8'h00, 8'h77, 1'b1, 0, 0, 9'h001,  1};
      vecs[3] = '{1'b1, 14'h3FFF, 8'hFF, 8'h00, 1'b1, 0, 0, 9'h001,  1};
      vecs[4] = '{1'b0, 14'h2AAA, 8'h00, 8'h00, 1'b0, 3, 0, 9'h000,  9};
      vecs[5] = '{1'b0, 14'h0000, 8'h00, 8'hFF, 1'b0, 1, 1, 9'h1FE,  9};
      vecs[6] = '{1'b1, 14'h1234, 8'h5A, 8'h00, 1'b0, 2, 0, 9'h000,  1};

      // Reset state
      tick();
      tick();
      chk("rst_busy", busy0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_tx_valid", tx_valid0, 0);
      chk("rst_tx_bit", tx_bit0, 0);
      chk("rst_addr", addr0, 0);
      chk("rst_wdata", wdata0, 0);
      chk("rst_we", we0, 0);
      chk("rst_split1", bsplit1, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy0, 0);

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
         tick();
      end

      // Split read: only the split-capable port enters SPLIT
      split_req = 1'b1;
      send_frame(1'b0, 14'h0042, 8'h00, 0);
      chk("split_valid1", valid1, 1);
      chk("split_start1", sstart1, 1);
      chk("split_start0", sstart0, 0);
      split_busy = 1'b1;
      tick();
      split_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("split_held1_%0d", i), bsplit1, 1);
         chk($sformatf("split_none0_%0d", i), bsplit0, 0);
      end
      split_busy  = 1'b0;
      split_ready = 1'b1;
      ready       = 1'b1;
      rdata       = 8'h3C;
      tick();
      split_ready = 1'b0;
      ready       = 1'b0;
      rdata       = 8'h00;
      chk("split_released1", bsplit1, 0);
      collect(r0, n0, r1, n1);
      chk("split_rsp1", r1, 9'h078);
      chk("split_len1", n1, 9);
      chk("split_rsp0", r0, 9'h078);
      chk("split_len0", n0, 9);
      tick();

      // Timeout: slave never answers
      send_frame(1'b0, 14'h0100, 8'h00, 0);
      tick();
      chk("tmo_busy", busy0, 1);
      waits = 1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (tx_valid0) break;
         waits++;
      end
      chk("tmo_wait_cycles", waits, 16);
      collect(r0, n0, r1, n1);
      chk("tmo_rsp0", r0, 9'h001);
      chk("tmo_len0", n0, 1);
      chk("tmo_rsp1", r1, 9'h001);
      chk("tmo_len1", n1, 1);
      tick();

      // Reset during request bit 10
      f = {8'h77, 14'h0ABC, 1'b1};
      for (int i = 0; i < 10; i++) begin
         rx_valid = 1'b1;
         rx_bit   = f[i];
         tick();
      end
      rx_valid = 1'b1;
      rx_bit   = f[10];
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy0, 0);
      chk("midrst_valid", valid0, 0);
      chk("midrst_tx_valid", tx_valid0, 0);
      chk("midrst_addr", addr0, 0);
      chk("midrst_wdata", wdata0, 0);
      chk("midrst_we", we0, 0);
      chk("midrst_busy1", busy1, 0);
      rx_valid = 1'b0;
      rx_bit   = 1'b0;
      tick();
      rst = 1'b0;
      ready = 1'b1;
      rdata = 8'hFF;
      tick();
      ready = 1'b0;
      rdata = 8'h00;
      chk("stray_ready_busy", busy0, 0);
      tick();
      chk("stray_ready_tx", tx_valid0, 0);
      run_txn(vecs[1], "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
